// File: rtl/range_session_arbiter.sv
// Round-robin owner of a shared range finder: clears it, streams the granted requester's
// samples through go/finish sequencing and returns the captured range tagged with the owner id.
module range_session_arbiter #(
   parameter  int WIDTH   = 16,
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   output logic [NUM_REQ-1:0]       grant,
   input  logic [NUM_REQ-1:0]       s_valid,
   input  logic [NUM_REQ-1:0]       s_last,
   input  logic [NUM_REQ*WIDTH-1:0] s_data,
   output logic [NUM_REQ-1:0]       s_ready,
   output logic                     rf_clear,
   output logic                     rf_go,
   output logic                     rf_finish,
   output logic [WIDTH-1:0]         rf_data,
   input  logic [WIDTH-1:0]         rf_range,
   input  logic                     rf_error,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_range,
   output logic [ID_W-1:0]          res_id,
   output logic                     res_error
);

   // state  | meaning
   // IDLE   | no owner; round-robin pick among active requests
   // CLEAR  | rf_clear pulse, finder min/max being reset
   // FIRST  | waiting for the owner's first sample (finder go)
   // RUN    | streaming; finder folds rf_data every cycle
   // FIN1   | single-sample session, finish with the held sample
   // RESULT | result presented until res_ready
   typedef enum logic [2:0] {IDLE, CLEAR, FIRST, RUN, FIN1, RESULT} state_t;

   state_t             state;
   logic [ID_W-1:0]    gidx;
   logic [ID_W-1:0]    last_id;
   logic [WIDTH-1:0]   hold;

   logic [WIDTH-1:0]   s_arr [NUM_REQ];
   logic [WIDTH-1:0]   g_data;
   logic               g_valid, g_last, g_req;
   logic               streaming, in_session, xfer, abort;
   logic               found_hi, found_any, pick_found;
   logic [ID_W-1:0]    pick_hi, pick_any, pick_id;
   logic [NUM_REQ-1:0] pick_oh;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         s_arr[i] = s_data[i*WIDTH +: WIDTH];
      end
   end

   assign g_data  = s_arr[gidx];
   assign g_valid = s_valid[gidx];
   assign g_last  = s_last[gidx];
   assign g_req   = req[gidx];

   assign streaming  = (state == FIRST) || (state == RUN);
   assign in_session = streaming || (state == CLEAR) || (state == FIN1);
   assign xfer       = streaming && g_valid;
   assign abort      = in_session && (rf_error || !g_req);

   assign s_ready   = streaming ? grant : '0;
   assign rf_go     = (state == FIRST) && xfer && !abort;
   assign rf_finish = ((state == RUN) && xfer && g_last && !abort) ||
                      ((state == FIN1) && !abort);

   always_comb begin
      rf_data = hold;
      if (state == FIRST || (state == RUN && g_valid)) begin
         rf_data = g_data;
      end
   end

   // Lowest index above last_id wins; otherwise wrap to the lowest active index,
   // which leaves the last-served requester with the lowest priority.
   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      pick_hi   = '0;
      pick_any  = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req[i]) begin
            found_any = 1'b1;
            pick_any  = ID_W'(i);
            if (ID_W'(i) > last_id) begin
               found_hi = 1'b1;
               pick_hi  = ID_W'(i);
            end
         end
      end
      pick_found = found_any;
      pick_id    = found_hi ? pick_hi : pick_any;
      pick_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         gidx      <= '0;
         last_id   <= ID_W'(NUM_REQ-1);
         hold      <= '0;
         rf_clear  <= 1'b0;
         res_valid <= 1'b0;
         res_range <= '0;
         res_id    <= '0;
         res_error <= 1'b0;
      end else begin
         rf_clear <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant    <= pick_oh;
                  gidx     <= pick_id;
                  rf_clear <= 1'b1;
                  state    <= CLEAR;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  grant     <= '0;
                  last_id   <= gidx;
                  state     <= IDLE;
               end
            end
            default: begin
               if (abort) begin
                  res_error <= 1'b1;
                  res_range <= '0;
                  res_id    <= gidx;
                  res_valid <= 1'b1;
                  state     <= RESULT;
               end else begin
                  case (state)
                     CLEAR: state <= FIRST;
                     FIRST: begin
                        if (xfer) begin
                           hold  <= g_data;
                           state <= g_last ? FIN1 : RUN;
                        end
                     end
                     RUN: begin
                        if (xfer && g_last) begin
                           res_range <= rf_range;
                           res_id    <= gidx;
                           res_error <= 1'b0;
                           res_valid <= 1'b1;
                           state     <= RESULT;
                        end else if (xfer) begin
                           hold <= g_data;
                        end
                     end
                     FIN1: begin
                        res_range <= rf_range;
                        res_id    <= gidx;
                        res_error <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter with a behavioural range finder and a result scoreboard.
module tb_range_session_arbiter;
   localparam int WIDTH = 16;
   localparam int NUM_REQ = 4;
   localparam int ID_W = 2;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_REQ-1:0]       req = '0;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       s_valid = '0;
   logic [NUM_REQ-1:0]       s_last = '0;
   logic [NUM_REQ*WIDTH-1:0] s_data = '0;
   logic [NUM_REQ-1:0]       s_ready;
   logic                     rf_clear, rf_go, rf_finish;
   logic [WIDTH-1:0]         rf_data;
   logic [WIDTH-1:0]         rf_range;
   logic                     rf_error = 1'b0;
   logic                     res_valid;
   logic                     res_ready = 1'b1;
   logic [WIDTH-1:0]         res_range;
   logic [ID_W-1:0]          res_id;
   logic                     res_error;

   range_session_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clock(clock), .reset(reset), .req(req), .grant(grant),
      .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
      .rf_clear(rf_clear), .rf_go(rf_go), .rf_finish(rf_finish), .rf_data(rf_data),
      .rf_range(rf_range), .rf_error(rf_error),
      .res_valid(res_valid), .res_ready(res_ready), .res_range(res_range),
      .res_id(res_id), .res_error(res_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural finder: clear, start on go, fold every cycle, range includes current data.
   logic [WIDTH-1:0] fm_min = '0, fm_max = '0;
   logic             fm_act = 1'b0;
   always @(posedge clock) begin
      if (rf_clear) fm_act <= 1'b0;
      else if (rf_go) begin
         fm_min <= rf_data;
         fm_max <= rf_data;
         fm_act <= 1'b1;
      end else if (fm_act) begin
         if (rf_data < fm_min) fm_min <= rf_data;
         if (rf_data > fm_max) fm_max <= rf_data;
      end
   end
   assign rf_range = (fm_max > rf_data ? fm_max : rf_data) - (fm_min < rf_data ? fm_min : rf_data);

   int clr_total = 0, go_total = 0, fin_total = 0, both_total = 0;
   logic [WIDTH-1:0] go_data = '0, fin_data = '0;
   always @(negedge clock) begin
      if (rf_clear) clr_total <= clr_total + 1;
      if (rf_go) begin
         go_total <= go_total + 1;
         go_data  <= rf_data;
      end
      if (rf_finish) begin
         fin_total <= fin_total + 1;
         fin_data  <= rf_data;
      end
      if (rf_go && rf_finish) both_total <= both_total + 1;
   end

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] rng;
      logic             err;
   } exp_t;
   exp_t sb_q[$];

   always @(negedge clock) begin
      if (!reset && res_valid && res_ready) begin
         if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_range", 32'(res_range), 32'(e.rng));
            chk("res_error", 32'(res_error), 32'(e.err));
         end
      end
   end

   task automatic push(input int id, input int rng, input logic err);
      exp_t e;
      e.id = ID_W'(id);
      e.rng = WIDTH'(rng);
      e.err = err;
      sb_q.push_back(e);
   endtask

   // Entered at posedge+1; returns at posedge+1 right after the transfer edge.
   task automatic xfer(input int id, input logic [WIDTH-1:0] d, input logic last);
      logic ok;
      ok = 1'b0;
      s_valid[id] = 1'b1;
      s_last[id]  = last;
      s_data[id*WIDTH +: WIDTH] = d;
      for (int n = 0; n < 50; n++) begin
         @(negedge clock);
         if (s_ready[id]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("xfer_timeout", 0, 1);
      @(posedge clock); #1;
      s_valid[id] = 1'b0;
      s_last[id]  = 1'b0;
   endtask

   task automatic wait_res_valid();
      logic ok;
      ok = res_valid;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clock);
         ok = res_valid;
      end
      if (!ok) chk("res_valid_timeout", 0, 1);
   endtask

   task automatic end_session();
      wait_res_valid();
      @(posedge clock); #1;
      req = '0;
   endtask

   task automatic wait_grant(input logic want_nz);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clock);
         if ((grant != 0) == want_nz) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   int c0, g0, f0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_rf_clear", 32'(rf_clear), 0);
      chk("rst_s_ready", 32'(s_ready), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // T1: back-to-back 7,3,9
      c0 = clr_total; g0 = go_total; f0 = fin_total;
      push(1, 6, 1'b0);
      req[1] = 1'b1;
      xfer(1, 16'd7, 1'b0);
      xfer(1, 16'd3, 1'b0);
      xfer(1, 16'd9, 1'b1);
      chk("t1_latency", 32'(res_valid), 1);
      end_session();
      chk("t1_clear_cycles", 32'(clr_total - c0), 1);
      chk("t1_go_count", 32'(go_total - g0), 1);
      chk("t1_go_data", 32'(go_data), 7);
      chk("t1_fin_count", 32'(fin_total - f0), 1);
      chk("t1_fin_data", 32'(fin_data), 9);

      // T2: gap cycles hold the previous sample
      push(1, 15, 1'b0);
      req[1] = 1'b1;
      xfer(1, 16'd5, 1'b0);
      @(negedge clock);
      chk("t2_gap_data0", 32'(rf_data), 5);
      @(negedge clock);
      chk("t2_gap_data1", 32'(rf_data), 5);
      chk("t2_gap_nofinish", 32'(rf_finish), 0);
      @(posedge clock); #1;
      xfer(1, 16'd20, 1'b1);
      end_session();

      // T3: single sample
      push(1, 0, 1'b0);
      req[1] = 1'b1;
      xfer(1, 16'd42, 1'b1);
      chk("t3_fin1_finish", 32'(rf_finish), 1);
      chk("t3_fin1_data", 32'(rf_data), 42);
      chk("t3_fin1_no_go", 32'(rf_go), 0);
      chk("t3_not_yet_valid", 32'(res_valid), 0);
      @(posedge clock); #1;
      chk("t3_latency", 32'(res_valid), 1);
      end_session();
      chk("t3_go_data", 32'(go_data), 42);

      // T4: all requesting, rotation 0,1,2,3,0
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(1'b1);
         chk("t4_grant_order", 32'(grant), 32'(4'b0001 << (k % 4)));
         @(posedge clock); #1;
         push(k % 4, 0, 1'b0);
         if (k == 1) res_ready = 1'b0;
         xfer(k % 4, WIDTH'(100 + k), 1'b1);
         if (k == 1) begin
            wait_res_valid();
            for (int j = 0; j < 3; j++) begin
               chk("t4_hold_valid", 32'(res_valid), 1);
               chk("t4_hold_grant", 32'(grant), 32'(4'b0010));
               @(negedge clock);
            end
            @(posedge clock); #1;
            res_ready = 1'b1;
         end
         if (k < 4) wait_grant(1'b0);
         else end_session();
      end

      // T5: finder error mid-RUN, then requester 3 runs normally
      push(2, 0, 1'b1);
      req[2] = 1'b1;
      xfer(2, 16'd10, 1'b0);
      rf_error = 1'b1;
      @(posedge clock); #1;
      rf_error = 1'b0;
      chk("t5_abort_valid", 32'(res_valid), 1);
      end_session();
      push(3, 7, 1'b0);
      req[3] = 1'b1;
      xfer(3, 16'd1, 1'b0);
      xfer(3, 16'd8, 1'b1);
      end_session();

      // T6: request dropped mid-RUN; result still waits for res_ready
      push(0, 0, 1'b1);
      req[0] = 1'b1;
      xfer(0, 16'd4, 1'b0);
      res_ready = 1'b0;
      req[0] = 1'b0;
      @(posedge clock); #1;
      chk("t6_drop_valid", 32'(res_valid), 1);
      chk("t6_drop_error", 32'(res_error), 1);
      @(posedge clock); #1;
      chk("t6_drop_waits", 32'(res_valid), 1);
      res_ready = 1'b1;
      @(posedge clock); #1;
      chk("t6_drop_accepted", 32'(res_valid), 0);

      // T6: async reset in RUN
      req[1] = 1'b1;
      xfer(1, 16'd5, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_s_ready", 32'(s_ready), 0);
      chk("t6_rst_res_valid", 32'(res_valid), 0);
      chk("t6_rst_go_finish", 32'({rf_go, rf_finish, rf_clear}), 0);
      req = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clock);
         chk("t6_no_result", 32'(res_valid), 0);
      end

      chk("go_finish_overlap", 32'(both_total), 0);
      chk("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
